// File: rtl/strobe_arb_if.sv
// Bundle between the strobe arbiter, its requesters and the shared strobe crossing.
// The master side drives requests and the returned ack. The slave side is the arbiter.
interface strobe_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       grant;
    logic                     strobe_out;
    logic [WIDTH-1:0]         data_out;
    logic [IDW-1:0]           src_id;
    logic                     ack_in;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        output req, req_data, ack_in,
        input  grant, strobe_out, data_out, src_id, busy, timeout_err
    );

    modport slave (
        input  req, req_data, ack_in,
        output grant, strobe_out, data_out, src_id, busy, timeout_err
    );
endinterface

// File: rtl/strobe_arbiter.sv
// Round-robin arbiter feeding one strobe clock-crossing channel.
// It keeps strobes spaced so the destination synchroniser never misses a toggle.
module strobe_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int GAP         = 4,
    parameter int USE_ACK     = 1,
    parameter int ACK_TIMEOUT = 255,
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          reset,
    strobe_arb_if.slave   bus
);
    localparam int CMAX = (GAP > ACK_TIMEOUT) ? GAP : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_GAP} state_t;

    state_t                        state;
    logic [IDW-1:0]                ptr;
    logic [CW-1:0]                 cnt;
    logic [NUM_REQ-1:0][WIDTH-1:0] pl;

    logic           hi_vld, lo_vld, sel_vld;
    logic [IDW-1:0] hi_idx, lo_idx, sel_idx;

    assign pl = bus.req_data;

    // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_vld = 1'b1;
                lo_idx = IDW'(i);
                if (IDW'(i) >= ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = IDW'(i);
                end
            end
        end
    end

    assign sel_vld = lo_vld;
    assign sel_idx = hi_vld ? hi_idx : lo_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ptr             <= '0;
            cnt             <= '0;
            bus.grant       <= '0;
            bus.strobe_out  <= 1'b0;
            bus.data_out    <= '0;
            bus.src_id      <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.grant       <= '0;
            bus.strobe_out  <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        bus.grant      <= NUM_REQ'(1) << sel_idx;
                        bus.strobe_out <= 1'b1;
                        bus.data_out   <= pl[sel_idx];
                        bus.src_id     <= sel_idx;
                        bus.busy       <= 1'b1;
                        ptr            <= (sel_idx == IDW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                        if (USE_ACK != 0) begin
                            state <= S_WAIT_ACK;
                            cnt   <= '0;
                        end else begin
                            state <= S_GAP;
                            cnt   <= CW'(GAP - 1);
                        end
                    end
                end
                S_WAIT_ACK: begin
                    // cnt holds cycles since the strobe; an ack in the strobe cycle itself is ignored.
                    if (bus.ack_in && !bus.strobe_out) begin
                        state <= S_GAP;
                        cnt   <= CW'(GAP - 1);
                    end else if (cnt >= CW'(ACK_TIMEOUT - 1)) begin
                        state           <= S_GAP;
                        cnt             <= CW'(GAP - 1);
                        bus.timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
